issue_ctrl: RTL

In-order issue controller between the decode stage and execute. Accepts one decoded instruction per cycle from the decoder over a valid/ready handshake. Tracks in-flight register and flag writes in a scoreboard and stalls on RAW/WAW and flag hazards. Holds issue for the latency of multi-cycle MUL/DIV ops, and inserts flush bubbles after a taken branch.

---
 rtl/issue_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue controller with register/flag scoreboard
// Stalls on RAW/WAW/flag hazards, holds for multi-cycle ops and flushes after taken branches.
module issue_ctrl #(
   parameter int MC_LATENCY   = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] dec_write_addr,
   input  logic [4:0] dec_addr_a,
   input  logic [4:0] dec_addr_b,
   input  logic       dec_regwrite,
   input  logic       dec_use_imm,
   input  logic       dec_setflags,
   input  logic       dec_flag_use,
   input  logic       dec_branch,
   input  logic       dec_multicycle,
   input  logic       wb_valid,
   input  logic [4:0] wb_addr,
   input  logic       wb_flags,
   output logic       issue_valid,
   output logic       flush,
   output logic       stall,
   output logic       busy
);

   typedef enum logic [1:0] {RUN, MULTI, FLUSH} state_t;

   localparam logic [3:0] MC_LOAD    = 4'(MC_LATENCY - 1);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] r_sb;
   logic [31:0] w_sb_nxt;
   logic        r_fb;
   logic        w_fb_nxt;
   logic        r_issue;
   logic        r_flush;
   logic        r_busy;
   logic        w_hazard;
   logic        w_accept;

   always_comb begin
      w_hazard = r_sb[dec_addr_a]
               | (~dec_use_imm & r_sb[dec_addr_b])
               | (dec_regwrite & r_sb[dec_write_addr])
               | (dec_flag_use & r_fb);
   end

   assign in_ready = (r_state == RUN) & ~w_hazard;
   assign w_accept = in_valid & in_ready;
   assign stall    = in_valid & ~in_ready;

   // Clear first so a same-cycle set on the same address wins.
   always_comb begin
      w_sb_nxt = r_sb;
      if (wb_valid) w_sb_nxt[wb_addr] = 1'b0;
      if (w_accept & dec_regwrite) w_sb_nxt[dec_write_addr] = 1'b1;
      w_fb_nxt = (r_fb & ~wb_flags) | (w_accept & dec_setflags);
   end

   // MULTI counts the accept cycle as its first execute cycle, so it leaves one
   // step earlier than FLUSH, which also spends a cycle with the counter at 0.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         RUN: begin
            if (w_accept & dec_branch) begin
               w_state_nxt = FLUSH;
               w_cnt_nxt   = FLUSH_LOAD;
            end else if (w_accept & dec_multicycle) begin
               w_state_nxt = MULTI;
               w_cnt_nxt   = MC_LOAD;
            end
         end
         MULTI: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = 4'd0;
            end
         end
         FLUSH: begin
            if (r_cnt == 4'd0) w_state_nxt = RUN;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= RUN;
         r_cnt   <= 4'd0;
         r_sb    <= 32'd0;
         r_fb    <= 1'b0;
         r_issue <= 1'b0;
         r_flush <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sb    <= w_sb_nxt;
         r_fb    <= w_fb_nxt;
         r_issue <= w_accept;
         r_flush <= w_accept & dec_branch;
         r_busy  <= (w_state_nxt != RUN) | (|w_sb_nxt) | w_fb_nxt;
      end
   end

   assign issue_valid = r_issue;
   assign flush       = r_flush;
   assign busy        = r_busy;

endmodule
